// File: rtl/nios2system_button_pkg.sv
// Shared constants for the Nios II push-button controller: register map
// and the idle (released) level of an active-low button.
package nios2system_button_pkg;

    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_RESERVED = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP  = 2'd3;

    // Buttons are active-low, so an untouched button reads 1.
    localparam logic BTN_RELEASED = 1'b1;

endpackage : nios2system_button_pkg

// File: rtl/nios2system_button_debounce.sv
// One-bit button conditioner: two-flop synchroniser followed by a
// hold-time debouncer. A new level is accepted only after the synchronised
// input has disagreed with the accepted level for DEBOUNCE_CYCLES cycles
// in a row; any shorter excursion is discarded.
module nios2system_button_debounce
    import nios2system_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic stable_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser, counter and accepted level; all return to "released".
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values and the ordering of statements is moot.
        if (reset) begin
            sync1_q  <= BTN_RELEASED;
            sync2_q  <= BTN_RELEASED;
            stable_q <= BTN_RELEASED;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Count while the input disagrees; accept at terminal count, else restart.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch can be inferred.
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable_o = stable_q;

endmodule : nios2system_button_debounce

// File: rtl/nios2system_button_ctrl.sv
// Avalon-MM push-button controller: debounced state, sticky press capture
// (write-1-to-clear), per-button interrupt mask and a registered level irq.
module nios2system_button_ctrl
    import nios2system_button_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;
    logic             wr_en;

    // Only the low WIDTH data bits are meaningful; the rest are don't-care.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_btn
        nios2system_button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .pin_i    (in_port[i]),
            .stable_o (stable[i])
        );
    end

    assign wr_en = chipselect && !write_n;
    // Press = debounced level going from released (1) to pressed (0).
    assign fall  = stable_dly_q & ~stable;

    // Register-file next state, read mux and interrupt condition.
    always_comb begin
        irqmask_d = irqmask_q;
        clr       = '0;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clr = writedata[WIDTH-1:0];
        end
        // A fresh press wins over a simultaneous acknowledge of the same bit.
        edgecap_d = (edgecap_q & ~clr) | fall;

        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d[WIDTH-1:0] = stable;
            ADDR_IRQMASK:  readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP:  readdata_d[WIDTH-1:0] = edgecap_q;
            default:       readdata_d = '0;
        endcase

        irq_d = |(edgecap_q & irqmask_q);
    end

    // Edge-detect delay, registers, read data and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_dly_q <= {WIDTH{BTN_RELEASED}};
            edgecap_q    <= '0;
            irqmask_q    <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            stable_dly_q <= stable;
            edgecap_q    <= edgecap_d;
            irqmask_q    <= irqmask_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule : nios2system_button_ctrl
